muldiv_unit: RTL and testbench

- Iterative multiply/divide unit; parametrised successor to the single-cycle ALU.
- Executes the 8 RV32M-style ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) over DATA_WIDTH cycles using a start/busy/valid handshake.
- Sits beside the ALU in the execute stage. The hazard unit stalls the pipeline while busy=1.
- flush lets a branch-mispredict kill an in-flight op.

---
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_muldiv_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit with a start/busy/valid handshake.
// Shift-add multiply and restoring divide, one bit per cycle, plus one sign/select cycle.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic                  flush,
  output logic                  busy,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0]         MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nxt;
  logic [2:0]           op_q;
  logic [W-1:0]         a_mag, b_mag;
  logic                 neg_res;
  logic [2*W-1:0]       prod;
  logic [W:0]           rem;
  logic [W-1:0]         quo;
  logic [CNT_WIDTH-1:0] cnt;

  logic                 accept, div_zero, div_ovf, fast;
  logic                 a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0]         a_mag_in, b_mag_in, fast_res;
  logic [W:0]           mul_sum, div_shift, div_diff;
  logic [2*W-1:0]       prod_s;
  logic [W-1:0]         quo_s, rem_s, final_res;

  // Operand decode and fast-path detection at accept time
  always_comb begin
    accept   = start && !flush && (state != CALC);
    div_zero = op[2] && (op2 == '0);
    div_ovf  = op[2] && !op[0] && (op1 == MIN_NEG) && (op2 == '1);
    fast     = div_zero || div_ovf;
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg    = a_signed && op1[W-1];
    b_neg    = b_signed && op2[W-1];
    a_mag_in = a_neg ? -op1 : op1;
    b_mag_in = b_neg ? -op2 : op2;
    if (op[1])
      fast_res = div_zero ? op1 : '0;
    else
      fast_res = div_zero ? '1 : op1;
  end

  // One iteration step for each algorithm, plus the final sign fix-up and select
  always_comb begin
    mul_sum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, a_mag} : '0);
    div_shift = {rem[W-1:0], quo[W-1]};
    div_diff  = div_shift - {1'b0, b_mag};
    prod_s    = neg_res ? -prod : prod;
    quo_s     = neg_res ? -quo : quo;
    rem_s     = neg_res ? -rem[W-1:0] : rem[W-1:0];
    case (op_q)
      3'b000:                 final_res = prod_s[W-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_s[2*W-1:W];
      3'b100, 3'b101:         final_res = quo_s;
      default:                final_res = rem_s;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = fast ? DONE : CALC;
        else        state_nxt = IDLE;
      end
      CALC:    if (cnt == CNT_LAST) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    busy  = (state == CALC);
    valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      a_mag   <= '0;
      b_mag   <= '0;
      neg_res <= 1'b0;
      prod    <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      result  <= '0;
    end else if (accept) begin
      op_q    <= op;
      a_mag   <= a_mag_in;
      b_mag   <= b_mag_in;
      neg_res <= (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
      prod    <= {{W{1'b0}}, b_mag_in};
      rem     <= '0;
      quo     <= a_mag_in;
      cnt     <= '0;
      if (fast) result <= fast_res;
    end else if (state == CALC && !flush) begin
      if (cnt != CNT_LAST) begin
        cnt <= cnt + 1'b1;
        if (op_q[2]) begin
          // Restoring step: keep the difference only when it did not go negative
          if (!div_diff[W]) begin
            rem <= div_diff;
            quo <= {quo[W-2:0], 1'b1};
          end else begin
            rem <= div_shift;
            quo <= {quo[W-2:0], 1'b0};
          end
        end else begin
          prod <= {mul_sum, prod[W-1:1]};
        end
      end else begin
        result <= final_res;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, random ops vs an
// arithmetic reference model, and handshake scenarios (flush, ignored start, back-to-back, reset).
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op = '0;
  logic [W-1:0]  op1 = '0, op2 = '0;
  logic          flush = 1'b0;
  logic          busy, valid;
  logic [W-1:0]  result;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_exp = '0;

  muldiv_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .op1(op1), .op2(op2),
    .flush(flush), .busy(busy), .valid(valid), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Edges from the accept edge until valid: divide fast paths finish on the accept edge itself
  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == MINV && b == 32'hFFFF_FFFF))) return 0;
    return W + 1;
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = f; op1 = a; op2 = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); op1 = $urandom; op2 = $urandom;
  endtask

  task automatic wait_valid(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!valid && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== '0) begin
      n_err++;
      $display("FAIL reset: busy=%b valid=%b result=%h, required 0/0/00000000", busy, valid, result);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [2:0]  fv [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] av [12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                             32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] bv [12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ev [12] = '{32'h1, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                             32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
    int lat, bcnt, el;
    for (int i = 0; i < 12; i++) begin
      el = exp_lat(fv[i], av[i], bv[i]);
      issue(fv[i], av[i], bv[i]);
      wait_valid(lat, bcnt);
      n_cmp++;
      if (result !== ev[i]) begin
        n_err++;
        $display("FAIL directed_result[%0d]: got %h, required %h", i, result, ev[i]);
      end
      n_cmp++;
      if (lat != el || bcnt != el) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: latency %0d busy %0d, required %0d/%0d", i, lat, bcnt, el, el);
      end
      last_exp = ev[i];
      @(posedge clk); #1;
      n_cmp++;
      if (valid !== 1'b0 || result !== last_exp) begin
        n_err++;
        $display("FAIL directed_pulse[%0d]: valid=%b result=%h, required 0/%h", i, valid, result, last_exp);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    logic [2:0]  f;
    logic [31:0] a, b, e;
    int lat, bcnt, el;
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 4) == 0) b = b >> $urandom_range(8, 30);
      e  = ref_model(f, a, b);
      el = exp_lat(f, a, b);
      issue(f, a, b);
      wait_valid(lat, bcnt);
      n_cmp++;
      if (result !== e || lat != el || bcnt != el) begin
        n_err++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d busy %0d, required %h lat %0d", i, f, a, b, result, lat, bcnt, e, el);
      end
      last_exp = e;
    end
  endtask

  task automatic test_flush;
    int vcnt;
    issue(3'd3, 32'h12345678, 32'h9ABCDEF0);
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_busy: busy=%b, required 0", busy);
    end
    vcnt = 0;
    repeat (40) begin
      if (valid) vcnt++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (vcnt != 0 || result !== last_exp) begin
      n_err++;
      $display("FAIL flush_quiet: valid cycles %0d result %h, required 0 / %h", vcnt, result, last_exp);
    end
  endtask

  task automatic test_ignored_start;
    logic [31:0] e;
    int lat, bcnt;
    e = ref_model(3'd5, 32'hDEADBEEF, 32'd1234);
    issue(3'd5, 32'hDEADBEEF, 32'd1234);
    repeat (5) @(posedge clk);
    @(negedge clk); start = 1'b1; op = 3'd0; op1 = 32'h3; op2 = 32'h0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(lat, bcnt);
    n_cmp++;
    if (result !== e || lat != W - 5) begin
      n_err++;
      $display("FAIL ignored_start: got %h lat %0d, required %h lat %0d", result, lat, e, W - 5);
    end
    last_exp = e;
  endtask

  task automatic test_back_to_back;
    logic [31:0] e1, e2;
    int lat, bcnt;
    e1 = ref_model(3'd1, 32'h87654321, 32'h7FFF0001);
    e2 = ref_model(3'd6, 32'hF0000001, 32'd77);
    issue(3'd1, 32'h87654321, 32'h7FFF0001);
    wait_valid(lat, bcnt);
    n_cmp++;
    if (result !== e1 || lat != W + 1) begin
      n_err++;
      $display("FAIL b2b_first: got %h lat %0d, required %h lat %0d", result, lat, e1, W + 1);
    end
    issue(3'd6, 32'hF0000001, 32'd77);
    wait_valid(lat, bcnt);
    n_cmp++;
    if (result !== e2 || lat != W + 1 || bcnt != W + 1) begin
      n_err++;
      $display("FAIL b2b_second: got %h lat %0d busy %0d, required %h lat %0d", result, lat, bcnt, e2, W + 1);
    end
    last_exp = e2;
  endtask

  task automatic test_reset_mid;
    issue(3'd0, 32'h0001_0003, 32'h0000_0007);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== '0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b valid=%b result=%h, required 0/0/00000000", busy, valid, result);
    end
    @(negedge clk); rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    n_cmp++;
    if (valid !== 1'b0 || result !== '0) begin
      n_err++;
      $display("FAIL reset_mid_quiet: valid=%b result=%h, required 0/00000000", valid, result);
    end
    last_exp = '0;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_flush;
    test_ignored_start;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
